// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the MEM stage and the data memory.
// Valid/ready on both the request and response sides.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-lane data memory with RISC-V sized loads/stores and a
// single-entry registered response buffer.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 16384,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_MIS = 2'b01;
  localparam logic [1:0] E_OOR = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  state_e state_q, state_d;

  logic          accept;
  logic [1:0]    err;
  logic [2:0]    f3;
  logic [31:0]   addr;
  logic [AW-1:0] idx;
  logic          ill;
  logic          mis;
  logic          oor;

  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   rd_word;

  logic [1:0]    err_q;
  logic          ld_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [31:0]   raw_q;

  logic [7:0]    sel_b;
  logic [15:0]   sel_h;
  logic [31:0]   ext;

  assign f3   = bus.req_funct3;
  assign addr = bus.req_addr;
  assign idx  = addr[AW+1:2];

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.req_ready = !bus.rsp_valid
                      || bus.rsp_ready;
  assign accept = bus.req_valid
               && bus.req_ready;

  assign ill = (f3 == 3'b011)
            || (f3 == 3'b110)
            || (f3 == 3'b111)
            || (bus.req_we && f3[2]);
  assign mis = ((f3[1:0] == 2'b01) && addr[0])
            || ((f3[1:0] == 2'b10)
                && (addr[1:0] != 2'b00));
  assign oor = |addr[31:AW+2];

  always_comb begin
    err = E_OK;
    if (ill)      err = E_ILL;
    else if (mis) err = E_MIS;
    else if (oor) err = E_OOR;
  end

  always_comb begin
    be    = 4'b0000;
    wlane = bus.req_wdata;
    unique case (1'b1)
      (f3[1:0] == 2'b00): begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{bus.req_wdata[7:0]}};
      end
      (f3[1:0] == 2'b01): begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wlane = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wlane = bus.req_wdata;
      end
    endcase
    if (!(accept && bus.req_we && err == E_OK))
      be = 4'b0000;
  end

  // Storage is not reset; contents survive rst_n.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (be[k]) ram[idx] <= wlane[8*k +: 8];
    end

    assign rd_word[8*k +: 8] = ram[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (bus.rsp_ready && !accept)
          state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= E_OK;
      ld_q  <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= 2'b00;
      raw_q <= 32'h0;
    end else if (accept) begin
      err_q <= err;
      ld_q  <= !bus.req_we && (err == E_OK);
      f3_q  <= f3;
      off_q <= addr[1:0];
      raw_q <= rd_word;
    end
  end

  assign sel_b = raw_q[{off_q, 3'b000} +: 8];
  assign sel_h = off_q[1] ? raw_q[31:16]
                          : raw_q[15:0];

  always_comb begin
    ext = raw_q;
    unique case (f3_q)
      3'b000:  ext = {{24{sel_b[7]}}, sel_b};
      3'b100:  ext = {24'h0, sel_b};
      3'b001:  ext = {{16{sel_h[15]}}, sel_h};
      3'b101:  ext = {16'h0, sel_h};
      default: ext = raw_q;
    endcase
  end

  // Stores and errors return zero data.
  assign bus.rsp_rdata = ld_q ? ext : 32'h0;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: sized access, errors,
// back-to-back throughput, backpressure and reset.
module tb_data_mem_lsu;

  localparam int DW = 1024;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  data_mem_lsu_if bus ();

  data_mem_lsu #(.DEPTH_WORDS(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic chk_rsp(
    input string       tag,
    input logic [31:0] exp_d,
    input logic [1:0]  exp_e
  );
    check({tag, ".v"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, ".e"}, 32'(bus.rsp_err), 32'(exp_e));
    check({tag, ".d"}, bus.rsp_rdata, exp_d);
  endtask

  // One request; response checked one cycle after accept.
  task automatic op(
    input string       tag,
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] exp_d,
    input logic [1:0]  exp_e
  );
    @(negedge clk);
    drive(we, f3, a, wd);
    @(negedge clk);
    chk_rsp(tag, exp_d, exp_e);
    bus.req_valid = 1'b0;
  endtask

  logic [31:0] alt_exp [8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    #1;
    check("rst.v", 32'(bus.rsp_valid), 32'd0);
    check("rst.d", bus.rsp_rdata, 32'h0);
    check("rst.e", 32'(bus.rsp_err), 32'd0);
    check("rst.rdy", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op("sw8", 1, W, 32'h8, 32'hDEADBEEF, 32'h0, 2'b00);
    op("lw8", 0, W, 32'h8, 32'h0, 32'hDEADBEEF, 2'b00);
    op("sb9", 1, B, 32'h9, 32'h00000080, 32'h0, 2'b00);
    op("lb9", 0, B, 32'h9, 32'h0, 32'hFFFFFF80, 2'b00);
    op("lbu9", 0, BU, 32'h9, 32'h0, 32'h00000080, 2'b00);
    op("lha", 0, H, 32'hA, 32'h0, 32'hFFFFDEAD, 2'b00);
    op("lw8b", 0, W, 32'h8, 32'h0, 32'hDEAD80EF, 2'b00);

    op("sw0", 1, W, 32'h0, 32'h11223344, 32'h0, 2'b00);
    op("lh3", 0, H, 32'h3, 32'h0, 32'h0, 2'b01);
    op("sw2", 1, W, 32'h2, 32'hCAFEF00D, 32'h0, 2'b01);
    op("lw0", 0, W, 32'h0, 32'h0, 32'h11223344, 2'b00);
    op("f011", 0, 3'b011, 32'h0, 32'h0, 32'h0, 2'b11);
    op("sh101", 1, HU, 32'h0, 32'hFFFF, 32'h0, 2'b11);
    op("oor", 0, W, 32'(4 * DW), 32'h0, 32'h0, 2'b10);
    op("sboor", 1, B, 32'(4 * DW), 32'h55, 32'h0, 2'b10);
    op("lw0c", 0, W, 32'h0, 32'h0, 32'h11223344, 2'b00);

    // Store then dependent load on consecutive edges.
    @(negedge clk);
    drive(1, W, 32'h10, 32'h12345678);
    @(negedge clk);
    chk_rsp("b2b.sw", 32'h0, 2'b00);
    drive(0, HU, 32'h12, 32'h0);
    @(negedge clk);
    chk_rsp("b2b.lhu", 32'h00001234, 2'b00);
    bus.req_valid = 1'b0;

    // Eight alternating store/load ops with no bubbles.
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk_rsp($sformatf("alt%0d", i - 1),
                alt_exp[i-1], 2'b00);
        check($sformatf("alt%0d.rdy", i - 1),
              32'(bus.req_ready), 32'd1);
      end
      if (i < 8) begin
        if (i % 2 == 0) begin
          drive(1, W, 32'(32'h40 + 4 * i),
                32'(32'hA0000000 + i * 32'h111));
          alt_exp[i] = 32'h0;
        end else begin
          drive(0, W, 32'(32'h40 + 4 * (i - 1)), 32'h0);
          alt_exp[i] = 32'(32'hA0000000 + (i - 1) * 32'h111);
        end
      end else begin
        bus.req_valid = 1'b0;
      end
    end

    // Backpressure: hold the response, then pop+accept together.
    @(negedge clk);
    drive(0, W, 32'h8, 32'h0);
    @(negedge clk);
    chk_rsp("bp.first", 32'hDEAD80EF, 2'b00);
    bus.rsp_ready = 1'b0;
    drive(0, W, 32'h10, 32'h0);
    #1;
    check("bp.rdy0", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d.rdy", i),
            32'(bus.req_ready), 32'd0);
      chk_rsp($sformatf("bp%0d", i), 32'hDEAD80EF, 2'b00);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp.rdy1", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk_rsp("bp.next", 32'h12345678, 2'b00);
    bus.req_valid = 1'b0;

    // Reset with a response pending; memory must survive.
    @(negedge clk);
    drive(0, W, 32'h10, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("mr.pend", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr.v", 32'(bus.rsp_valid), 32'd0);
    check("mr.d", bus.rsp_rdata, 32'h0);
    check("mr.e", 32'(bus.rsp_err), 32'd0);
    check("mr.rdy", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    op("mr.lw8", 0, W, 32'h8, 32'h0, 32'hDEAD80EF, 2'b00);
    op("mr.lw10", 0, W, 32'h10, 32'h0, 32'h12345678, 2'b00);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised byte-lane data memory with a valid/ready request port, RISC-V sized loads and stores, and error reporting. Sits behind the pipelined core's MEM stage and replaces the fixed word-only, negedge-written data memory. Executes SB/SH/SW and LB/LH/LW/LBU/LHU from `funct3`, flags misaligned, out-of-range and illegal accesses, and returns a registered response through a single-entry output buffer.

## Interface
- `DEPTH_WORDS`, 16384: number of 32-bit words; power of two, ≥ 4.
- `AW`, log2(`DEPTH_WORDS`): word-index width, derived, not overridden.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low byte/half used for SB/SH.
- `rsp_valid` out 1: response held in the output buffer.
- `rsp_ready` in 1: consumer takes the response on an edge where `rsp_valid && rsp_ready`.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 2: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

## Operation
- Storage: four byte-lane arrays of `DEPTH_WORDS` x 8. Index is `req_addr[AW+1:2]`. Lane k holds bits [8k+7:8k], little-endian. Array contents are not reset.
- Error check on the accepted request, in priority order:
  - illegal: funct3 ∈ {011,110,111}, or `req_we` with funct3 ∈ {100,101}.
  - misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - out of range: `addr[31:AW+2]` ≠ 0.
- An erroring request touches no array. Its response carries `rsp_rdata`=0 and the code above.
- Store lane enables:
  - SB: lane `addr[1:0]` gets `wdata[7:0]`.
  - SH: lanes {`addr[1]`*2, +1} get `wdata[15:0]`.
  - SW: all lanes get `wdata`.
  - Write happens on the accepting edge. The response is ok, rdata 0.
- Load: all four lanes are read into a raw word register on the accepting edge. `funct3` and `addr[1:0]` are registered alongside. `rsp_rdata` is built from the registered raw word:
  - B/H: sign-extend the selected byte/half.
  - BU/HU: zero-extend.
  - W: whole word.
- Output buffer, one entry:
  - `req_ready = !rsp_valid || rsp_ready`.
  - Accept with buffer free, or with simultaneous pop: buffer reloads, `rsp_valid` stays or goes 1.
  - Pop without accept: `rsp_valid` goes 0.
  - Neither: all response outputs hold stable.
- Internal states: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on pop with no accept.
  - FULL→FULL on pop+accept, or on stall.

## Timing
- Reset (async assert, sync release): `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `req_ready`=1. Registered funct3/offset/raw word clear to 0.
- Latency: request accepted at edge N gives response visible after edge N, i.e. in cycle N+1, for loads, stores and errors alike.
- Throughput: one request per cycle while `rsp_ready`=1.
- Store at edge N followed by a load to the same word accepted at N+1: the load returns the new data. No bypass is needed, since array write and read are on different edges.
- `rsp_ready` low: `req_ready` drops in the same cycle (combinational). No request is lost or duplicated.
- Reset mid-operation: a pending response is discarded. A store accepted on the same edge that reset asserts is not guaranteed. Array contents survive reset.

## Test plan
- Reset, then SW 0x8 = 0xDEADBEEF; LW 0x8 → rdata 0xDEADBEEF, err 00, response one cycle after accept.
- SB 0x9 = 0x80; then:
  - LB 0x9 → 0xFFFFFF80
  - LBU 0x9 → 0x00000080
  - LH 0xA → 0xFFFFDEAD
  - LW 0x8 → 0xDEAD80EF
- LH 0x3, SW 0x2 → err 01, rdata 0; memory at 0x0 unchanged on readback. funct3=011 → err 11. SH with funct3=101 → err 11. Address 4·`DEPTH_WORDS` → err 10.
- Back-to-back: SW 0x10 = 0x12345678 then LHU 0x12 on consecutive cycles → 0x00001234. Also 8 alternating ops with `rsp_ready`=1 → 8 responses in order, no bubbles.
- Backpressure: hold `rsp_ready`=0 for 3 cycles with `req_valid`=1 → `req_ready`=0 and `rsp_*` stable. Release → the held response pops and the next request is accepted on the same edge.
- Assert `rst_n`=0 while `rsp_valid`=1 → outputs take reset values immediately. After release, a load returns data written before the reset.
